// File: rtl/wire_cmd_responder.sv
// Host command responder over FrontPanel wires: detects a new sequence number,
// runs ADD/SUB/MUL on latched operands, and commits result and ack atomically.
module wire_cmd_responder (
   input  logic        ti_clk,
   input  logic        rst,
   input  logic [31:0] cmd_wire,
   input  logic [31:0] opa_wire,
   input  logic [31:0] opb_wire,
   output logic [31:0] result_wire,
   output logic [31:0] status_wire
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t      state;
   logic [7:0]  last_seq;
   logic [7:0]  ack_seq;
   logic [1:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [63:0] mcand;
   logic [63:0] acc;
   logic [63:0] acc_nxt;
   logic [4:0]  bit_cnt;
   logic [31:0] res_q;
   logic        carry_q;
   logic        err_q;
   logic        busy;
   logic        carry_f;
   logic        err_f;
   logic        zero_f;
   logic [15:0] done_count;
   logic        unused_cmd_bits;

   assign unused_cmd_bits = ^cmd_wire[31:10];
   assign status_wire     = {done_count, 4'b0000, zero_f, err_f, carry_f, busy, ack_seq};

   // opb doubles as the multiplier shift register, consumed LSB first
   always_comb begin
      acc_nxt = acc;
      if (opb[0]) acc_nxt = acc + mcand;
   end

   always_ff @(posedge ti_clk) begin
      if (rst) begin
         state       <= IDLE;
         last_seq    <= '0;
         ack_seq     <= '0;
         op          <= '0;
         opa         <= '0;
         opb         <= '0;
         mcand       <= '0;
         acc         <= '0;
         bit_cnt     <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         err_q       <= 1'b0;
         busy        <= 1'b0;
         carry_f     <= 1'b0;
         err_f       <= 1'b0;
         zero_f      <= 1'b0;
         done_count  <= '0;
         result_wire <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_wire[7:0] != last_seq) begin
                  last_seq <= cmd_wire[7:0];
                  op       <= cmd_wire[9:8];
                  opa      <= opa_wire;
                  opb      <= opb_wire;
                  mcand    <= {32'd0, opa_wire};
                  acc      <= '0;
                  bit_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               case (op)
                  2'd0: begin
                     {carry_q, res_q} <= {1'b0, opa} + {1'b0, opb};
                     err_q            <= 1'b0;
                     state            <= DONE;
                  end
                  2'd1: begin
                     res_q   <= opa - opb;
                     carry_q <= (opa < opb);
                     err_q   <= 1'b0;
                     state   <= DONE;
                  end
                  2'd2: begin
                     acc     <= acc_nxt;
                     mcand   <= mcand << 1;
                     opb     <= opb >> 1;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd31) begin
                        res_q   <= acc_nxt[31:0];
                        carry_q <= |acc_nxt[63:32];
                        err_q   <= 1'b0;
                        state   <= DONE;
                     end
                  end
                  default: begin
                     res_q   <= '0;
                     carry_q <= 1'b0;
                     err_q   <= 1'b1;
                     state   <= DONE;
                  end
               endcase
            end
            DONE: begin
               result_wire <= res_q;
               carry_f     <= carry_q;
               err_f       <= err_q;
               zero_f      <= (res_q == 32'd0);
               ack_seq     <= last_seq;
               busy        <= 1'b0;
               done_count  <= done_count + 16'd1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wire_cmd_responder.sv
// Bench for wire_cmd_responder: scoreboard of expected commits checked by a
// negedge monitor, plus per-scenario latency, busy and reset checks.
module tb_wire_cmd_responder;

   logic        ti_clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] cmd_wire = '0;
   logic [31:0] opa_wire = '0;
   logic [31:0] opb_wire = '0;
   logic [31:0] result_wire;
   logic [31:0] status_wire;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [7:0]  seq;
      logic [31:0] result;
      logic        carry;
      logic        err;
      logic        zero;
   } exp_t;

   exp_t sb[$];

   wire_cmd_responder dut (
      .ti_clk      (ti_clk),
      .rst         (rst),
      .cmd_wire    (cmd_wire),
      .opa_wire    (opa_wire),
      .opb_wire    (opb_wire),
      .result_wire (result_wire),
      .status_wire (status_wire)
   );

   always #5 ti_clk = ~ti_clk;

   function automatic exp_t model(input logic [1:0] op, input logic [7:0] seq,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [32:0] s;
      logic [63:0] p;
      e.seq = seq;
      e.carry = 1'b0;
      e.err = 1'b0;
      case (op)
         2'd0: begin s = {1'b0, a} + {1'b0, b}; e.result = s[31:0]; e.carry = s[32]; end
         2'd1: begin e.result = a - b; e.carry = (a < b); end
         2'd2: begin p = {32'd0, a} * {32'd0, b}; e.result = p[31:0]; e.carry = |p[63:32]; end
         default: begin e.result = '0; e.err = 1'b1; end
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   // Commit monitor: every done_count step must match the oldest expected entry
   logic [15:0] prev_dc = '0;
   logic [7:0]  prev_ack = '0;
   logic [31:0] prev_res = '0;
   exp_t        m;
   always @(negedge ti_clk) begin
      if (!rst && status_wire[31:16] != 16'd0) begin
         if (status_wire[31:16] != prev_dc) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL commit_unexpected: got seq %0d result %h, required no commit",
                        status_wire[7:0], result_wire);
            end else begin
               m = sb.pop_front();
               if (result_wire !== m.result || status_wire[7:0] !== m.seq ||
                   status_wire[8] !== 1'b0 || status_wire[9] !== m.carry ||
                   status_wire[10] !== m.err || status_wire[11] !== m.zero ||
                   status_wire[15:12] !== 4'b0000 || status_wire[31:16] !== prev_dc + 16'd1)
                  $display("FAIL commit_seq%0d: got result %h status %h, required result %h ack %0d carry %b err %b zero %b count %0d",
                           m.seq, result_wire, status_wire, m.result, m.seq, m.carry, m.err, m.zero, prev_dc + 16'd1);
               else
                  n_pass++;
            end
         end else if (status_wire[7:0] != prev_ack || result_wire != prev_res) begin
            n_total++;
            $display("FAIL commit_atomic: got ack %0d result %h, required ack %0d result %h",
                     status_wire[7:0], result_wire, prev_ack, prev_res);
         end
      end
      prev_dc  = status_wire[31:16];
      prev_ack = status_wire[7:0];
      prev_res = result_wire;
   end

   task automatic drive(input logic [1:0] op, input logic [7:0] seq,
                        input logic [31:0] a, input logic [31:0] b, input bit push);
      @(negedge ti_clk);
      cmd_wire = {22'd0, op, seq};
      opa_wire = a;
      opb_wire = b;
      if (push) sb.push_back(model(op, seq, a, b));
   endtask

   // Counts rising edges until done_count moves; -1 if it never does
   task automatic wait_done(output int cycles, output int busy_cycles);
      logic [15:0] start;
      bit hit;
      start = status_wire[31:16];
      cycles = 0;
      busy_cycles = 0;
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge ti_clk);
         #1;
         cycles++;
         if (status_wire[31:16] != start) begin
            hit = 1;
            break;
         end
         if (status_wire[8]) busy_cycles++;
      end
      if (!hit) cycles = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cmd_wire = '0;
      repeat (3) @(posedge ti_clk);
      @(negedge ti_clk);
      n_total++;
      if (result_wire !== 32'd0 || status_wire !== 32'd0)
         $display("FAIL reset_values: got result %h status %h, required 0 0", result_wire, status_wire);
      else n_pass++;
      rst = 1'b0;
      repeat (5) @(posedge ti_clk);
      #1;
      n_total++;
      if (status_wire !== 32'd0)
         $display("FAIL seq0_no_trigger: got status %h, required 00000000", status_wire);
      else n_pass++;
   endtask

   task automatic test_add;
      int c, b;
      drive(2'd0, 8'd1, 32'hFFFF_FFFF, 32'd2, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 3 || b !== 2)
         $display("FAIL add_latency: got edges %0d busy %0d, required 3 2", c, b);
      else n_pass++;
      n_total++;
      if (result_wire !== 32'h1 || status_wire !== 32'h0001_0201)
         $display("FAIL add_values: got result %h status %h, required 00000001 00010201", result_wire, status_wire);
      else n_pass++;
   endtask

   task automatic test_sub;
      int c, b;
      drive(2'd1, 8'd2, 32'd5, 32'd7, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 3 || result_wire !== 32'hFFFF_FFFE || status_wire[9] !== 1'b1 || status_wire[11] !== 1'b0)
         $display("FAIL sub_borrow: got edges %0d result %h status %h, required 3 fffffffe borrow 1 zero 0",
                  c, result_wire, status_wire);
      else n_pass++;
      drive(2'd1, 8'd3, 32'h1234, 32'h1234, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 3 || result_wire !== 32'd0 || status_wire[9] !== 1'b0 || status_wire[11] !== 1'b1)
         $display("FAIL sub_zero: got edges %0d result %h status %h, required 3 00000000 borrow 0 zero 1",
                  c, result_wire, status_wire);
      else n_pass++;
   endtask

   task automatic test_mul;
      int c, b;
      drive(2'd2, 8'd4, 32'h0001_0000, 32'h0001_0001, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 34 || b !== 33)
         $display("FAIL mul_latency: got edges %0d busy %0d, required 34 33", c, b);
      else n_pass++;
      n_total++;
      if (result_wire !== 32'h0001_0000 || status_wire[9] !== 1'b1 || status_wire[7:0] !== 8'd4)
         $display("FAIL mul_values: got result %h status %h, required 00010000 carry 1 ack 4", result_wire, status_wire);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int c, b;
      logic [15:0] start;
      start = status_wire[31:16];
      drive(2'd2, 8'd5, 32'd3, 32'h8000_0005, 1);
      repeat (3) @(posedge ti_clk);
      drive(2'd1, 8'd6, 32'd9, 32'd9, 0);
      repeat (3) @(posedge ti_clk);
      drive(2'd0, 8'd7, 32'd100, 32'd23, 1);
      wait_done(c, b);
      n_total++;
      if (c < 0 || status_wire[7:0] !== 8'd5)
         $display("FAIL b2b_mul: got edges %0d ack %0d, required commit with ack 5", c, status_wire[7:0]);
      else n_pass++;
      wait_done(c, b);
      n_total++;
      if (c !== 3 || status_wire[7:0] !== 8'd7 || result_wire !== 32'd123)
         $display("FAIL b2b_latest: got edges %0d ack %0d result %0d, required 3 7 123", c, status_wire[7:0], result_wire);
      else n_pass++;
      repeat (40) @(posedge ti_clk);
      #1;
      n_total++;
      if (status_wire[31:16] !== start + 16'd2)
         $display("FAIL b2b_count: got %0d, required %0d", status_wire[31:16], start + 16'd2);
      else n_pass++;
   endtask

   task automatic test_ignored_change;
      logic [31:0] st;
      st = status_wire;
      drive(2'd3, 8'd7, 32'hABCD, 32'h1, 0);
      repeat (10) @(posedge ti_clk);
      #1;
      n_total++;
      if (status_wire !== st || result_wire !== 32'd123)
         $display("FAIL operand_only_change: got status %h result %h, required %h 0000007b", status_wire, result_wire, st);
      else n_pass++;
   endtask

   task automatic test_op3_wrap;
      int c, b;
      drive(2'd3, 8'hFF, 32'd7, 32'd9, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 3 || result_wire !== 32'd0 || status_wire[10] !== 1'b1 || status_wire[9] !== 1'b0)
         $display("FAIL op3_error: got edges %0d result %h status %h, required 3 00000000 err 1 carry 0",
                  c, result_wire, status_wire);
      else n_pass++;
      drive(2'd0, 8'h00, 32'd1, 32'd2, 1);
      wait_done(c, b);
      n_total++;
      if (c !== 3 || status_wire[7:0] !== 8'h00 || result_wire !== 32'd3 || status_wire[10] !== 1'b0)
         $display("FAIL seq_wrap: got edges %0d ack %0d result %0d, required 3 0 3", c, status_wire[7:0], result_wire);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int c, b;
      drive(2'd2, 8'h10, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      @(posedge ti_clk);
      repeat (10) @(posedge ti_clk);
      @(negedge ti_clk);
      rst = 1'b1;
      @(posedge ti_clk);
      #1;
      n_total++;
      if (result_wire !== 32'd0 || status_wire !== 32'd0)
         $display("FAIL reset_mid: got result %h status %h, required 0 0", result_wire, status_wire);
      else n_pass++;
      @(negedge ti_clk);
      rst = 1'b0;
      sb.push_back(model(2'd2, 8'h10, 32'hDEAD_BEEF, 32'h1234_5678));
      wait_done(c, b);
      n_total++;
      if (c !== 34 || status_wire[31:16] !== 16'd1)
         $display("FAIL post_reset_trigger: got edges %0d count %0d, required 34 1", c, status_wire[31:16]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_back_to_back();
      test_ignored_change();
      test_op3_wrap();
      test_reset_mid();
      repeat (2) @(negedge ti_clk);
      n_total++;
      if (sb.size() != 0)
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
